// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, divisor width and parity helper shared by the UART TX and RX controllers.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, ALIGN, START, DATA, PARITY, STOP} uart_state_t;

    localparam int DVSR_W = 11;
    localparam logic [DVSR_W-1:0] DVSR_DEFAULT = 11'd325;

    // Callers zero-extend narrower frames; the extra zeros do not change the XOR.
    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return ^data ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: sequences one serial frame per accepted byte on the baud tick and owns the
// baud divisor, deferring mid-frame divisor writes until the frame has finished.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DBIT = 8,
    parameter int SB_TICK = 1,
    parameter bit PARITY_EN = 1'b0,
    parameter bit PARITY_ODD = 1'b0,
    parameter logic [DVSR_W-1:0] DVSR_RST = DVSR_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              baud_trig_tx,
    output logic [DVSR_W-1:0] dvsr,
    input  logic              cfg_wr,
    input  logic [DVSR_W-1:0] cfg_dvsr,
    output logic              cfg_err,
    input  logic [DBIT-1:0]   tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam logic [2:0] LAST_BIT = 3'(DBIT - 1);
    localparam logic [2:0] LAST_STOP = 3'(SB_TICK - 1);

    uart_state_t       state, state_n;
    logic [DBIT-1:0]   shift, shift_n;
    logic [2:0]        cnt, cnt_n;
    logic              par, par_n;
    logic              tx_n, done_n;
    logic              finish, wr_ok;
    logic [DVSR_W-1:0] pend;
    logic              pend_valid;

    assign tx_ready = state == IDLE && !pend_valid;
    assign tx_busy  = state != IDLE;
    assign wr_ok    = cfg_wr && cfg_dvsr != '0;
    assign finish   = state == STOP && baud_trig_tx && cnt == LAST_STOP;

    always_comb begin
        state_n = state;
        shift_n = shift;
        cnt_n   = cnt;
        par_n   = par;
        tx_n    = tx;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (tx_valid && tx_ready) begin
                    state_n = ALIGN;
                    shift_n = tx_data;
                    par_n   = parity_bit(8'(tx_data), PARITY_ODD);
                end
            end
            ALIGN: if (baud_trig_tx) begin
                state_n = START;
                tx_n    = 1'b0;
            end
            START: if (baud_trig_tx) begin
                state_n = DATA;
                tx_n    = shift[0];
                cnt_n   = '0;
            end
            DATA: if (baud_trig_tx) begin
                state_n = cnt != LAST_BIT ? DATA : (PARITY_EN ? PARITY : STOP);
                shift_n = shift >> 1;
                cnt_n   = cnt != LAST_BIT ? cnt + 3'd1 : 3'd0;
                tx_n    = cnt != LAST_BIT ? shift[1] : (PARITY_EN ? par : 1'b1);
            end
            PARITY: if (baud_trig_tx) begin
                state_n = STOP;
                tx_n    = 1'b1;
                cnt_n   = '0;
            end
            STOP: if (baud_trig_tx) begin
                state_n = finish ? IDLE : STOP;
                cnt_n   = cnt + 3'd1;
                done_n  = finish;
            end
            default: state_n = IDLE;
        endcase
    end

    // A write landing on the final stop edge is newer than anything pending, so it wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shift      <= '0;
            cnt        <= '0;
            par        <= 1'b0;
            tx         <= 1'b1;
            tx_done    <= 1'b0;
            cfg_err    <= 1'b0;
            dvsr       <= DVSR_RST;
            pend       <= '0;
            pend_valid <= 1'b0;
        end else begin
            state   <= state_n;
            shift   <= shift_n;
            cnt     <= cnt_n;
            par     <= par_n;
            tx      <= tx_n;
            tx_done <= done_n;
            cfg_err <= cfg_wr && cfg_dvsr == '0;
            if (wr_ok && (state == IDLE || finish))
                dvsr <= cfg_dvsr;
            else if (finish && pend_valid)
                dvsr <= pend;
            if (wr_ok && state != IDLE && !finish) begin
                pend       <= cfg_dvsr;
                pend_valid <= 1'b1;
            end else if (finish) begin
                pend_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: checks an 8N1 and an 8E2 uart_tx_ctrl against a frame-level line model,
// using a vector table, hand-written corner sequences and randomized traffic.
module tb_uart_tx_ctrl;
    import uart_pkg::*;

    typedef struct {
        logic [10:0] wr;
        logic [7:0]  data;
        int          exp_d;
        logic        exp_e;
    } vec_t;

    logic        clk = 1'b0, rst = 1'b1, sel = 1'b0;
    logic        cfg_wr = 1'b0, tx_valid = 1'b0, hold_v = 1'b0;
    logic [10:0] cfg_dvsr = '0;
    logic [7:0]  tx_data = '0;
    logic [10:0] dvsr_a, dvsr_b, bc_a = '0, bc_b = '0;
    logic        tick_a, tick_b, err_a, err_b, rdy_a, rdy_b, tx_a, tx_b;
    logic        busy_a, busy_b, done_a, done_b;
    logic        m_tx, m_ready, m_busy, m_done, m_err;
    logic [10:0] m_dvsr;
    int          tests = 0, fails = 0;
    int          exp_dvsr [2] = '{325, 325};
    int          w_at [2] = '{-1, -1};
    logic [10:0] w_v [2] = '{11'd0, 11'd0};

    always #5 clk = ~clk;

    // Free-running baud generators, as the real one would run from each controller's dvsr.
    assign tick_a = bc_a == dvsr_a - 11'd1;
    assign tick_b = bc_b == dvsr_b - 11'd1;
    always @(posedge clk) begin
        bc_a <= (rst || bc_a >= dvsr_a - 11'd1) ? 11'd0 : bc_a + 11'd1;
        bc_b <= (rst || bc_b >= dvsr_b - 11'd1) ? 11'd0 : bc_b + 11'd1;
    end

    assign m_tx    = sel ? tx_b : tx_a;
    assign m_ready = sel ? rdy_b : rdy_a;
    assign m_busy  = sel ? busy_b : busy_a;
    assign m_done  = sel ? done_b : done_a;
    assign m_err   = sel ? err_b : err_a;
    assign m_dvsr  = sel ? dvsr_b : dvsr_a;

    uart_tx_ctrl dut_a (
        .clk(clk), .rst(rst), .baud_trig_tx(tick_a), .dvsr(dvsr_a),
        .cfg_wr(cfg_wr && !sel), .cfg_dvsr(cfg_dvsr), .cfg_err(err_a),
        .tx_data(tx_data), .tx_valid(tx_valid && !sel), .tx_ready(rdy_a),
        .tx(tx_a), .tx_busy(busy_a), .tx_done(done_a)
    );

    uart_tx_ctrl #(.SB_TICK(2), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_b (
        .clk(clk), .rst(rst), .baud_trig_tx(tick_b), .dvsr(dvsr_b),
        .cfg_wr(cfg_wr && sel), .cfg_dvsr(cfg_dvsr), .cfg_err(err_b),
        .tx_data(tx_data), .tx_valid(tx_valid && sel), .tx_ready(rdy_b),
        .tx(tx_b), .tx_busy(busy_b), .tx_done(done_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (dut %0d): got %0d expected %0d at %0t", name, sel, act, exp, $time);
        end
    endtask

    task automatic cfg_write(input logic [10:0] v, input int exp_d, input logic exp_e);
        cfg_wr = 1'b1;
        cfg_dvsr = v;
        @(negedge clk);
        cfg_wr = 1'b0;
        check("cfg_err_pulse", m_err, exp_e);
        check("dvsr_idle_write", m_dvsr, exp_d);
        exp_dvsr[sel] = exp_d;
        @(negedge clk);
        check("cfg_err_clear", m_err, 0);
    endtask

    task automatic accept(input logic [7:0] d, input logic keep);
        tx_data = d;
        tx_valid = 1'b1;
        for (int k = 0; k < 400 && !m_ready; k++) @(negedge clk);
        check("accept_ready", m_ready, 1);
        @(negedge clk);
        tx_valid = keep;
    endtask

    // Expected line: start, data LSB first, optional even parity, stop bits; each held p clocks.
    task automatic frame(input logic [7:0] d);
        int p = exp_dvsr[sel];
        int nb = sel ? 12 : 10;
        logic [11:0] bits = {2'b11, sel ? ^d : 1'b1, d, 1'b0};
        int line_e = 0, ctl_e = 0, errs = 0, exp_errs = 0, pend = 0;
        bit pv = 1'b0;
        for (int k = 0; k < 4000 && m_tx; k++) @(negedge clk);
        check("frame_start", m_tx, 0);
        if (m_tx) return;
        for (int i = 0; i < nb * p; i++) begin
            cfg_wr = 1'b0;
            line_e += int'(m_tx !== bits[i / p]);
            ctl_e += int'(m_done || m_ready || !m_busy || m_dvsr != 11'(p));
            errs += int'(m_err);
            if (i == 0) tx_valid = hold_v;
            for (int w = 0; w < 2; w++) begin
                if (w_at[w] == i) begin
                    cfg_wr = 1'b1;
                    cfg_dvsr = w_v[w];
                    if (w_v[w] == 0) exp_errs++;
                    else begin
                        pend = int'(w_v[w]);
                        pv = 1'b1;
                    end
                end
            end
            @(negedge clk);
        end
        cfg_wr = 1'b0;
        errs += int'(m_err);
        if (pv) exp_dvsr[sel] = pend;
        w_at = '{-1, -1};
        check("line_bits", line_e, 0);
        check("frame_ctl", ctl_e, 0);
        check("done_pulse", m_done, 1);
        check("busy_end", m_busy, 0);
        check("ready_end", m_ready, 1);
        check("dvsr_end", m_dvsr, exp_dvsr[sel]);
        check("cfg_err_count", errs, exp_errs);
        @(negedge clk);
        check("done_one_clk", m_done, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [7];
        tbl[0] = '{11'd4, 8'hA5, 4, 1'b0};
        tbl[1] = '{11'd0, 8'h3C, 4, 1'b1};
        tbl[2] = '{11'd3, 8'h00, 3, 1'b0};
        tbl[3] = '{11'd1, 8'h69, 1, 1'b0};
        tbl[4] = '{11'd7, 8'hFF, 7, 1'b0};
        tbl[5] = '{11'd0, 8'h81, 7, 1'b1};
        tbl[6] = '{11'd5, 8'h5A, 5, 1'b0};
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            check("rst_tx", m_tx, 1);
            check("rst_busy", m_busy, 0);
            check("rst_done", m_done, 0);
            check("rst_cfg_err", m_err, 0);
            check("rst_dvsr", m_dvsr, 325);
            check("rst_ready", m_ready, 1);
        end
        sel = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            cfg_write(tbl[i].wr, tbl[i].exp_d, tbl[i].exp_e);
            accept(tbl[i].data, 1'b0);
            frame(tbl[i].data);
        end
        // Two nonzero writes mid-frame: last wins, applied when the frame ends.
        w_at = '{7, 23};
        w_v = '{11'd8, 11'd6};
        accept(8'h3C, 1'b0);
        frame(8'h3C);
        accept(8'hC3, 1'b0);
        frame(8'hC3);
        // Zero writes are rejected in IDLE and mid-frame; a zero after a good one keeps the good one.
        cfg_write(11'd0, 6, 1'b1);
        w_at = '{3, 20};
        w_v = '{11'd0, 11'd0};
        accept(8'h4B, 1'b0);
        frame(8'h4B);
        w_at = '{5, 9};
        w_v = '{11'd9, 11'd0};
        accept(8'hB4, 1'b0);
        frame(8'hB4);
        // Back-to-back frames with tx_valid held.
        hold_v = 1'b1;
        accept(8'h00, 1'b1);
        tx_data = 8'hFF;
        frame(8'h00);
        hold_v = 1'b0;
        frame(8'hFF);
        // Divisor write and accept on the same IDLE edge.
        cfg_wr = 1'b1;
        cfg_dvsr = 11'd4;
        tx_data = 8'h96;
        tx_valid = 1'b1;
        @(negedge clk);
        cfg_wr = 1'b0;
        tx_valid = 1'b0;
        exp_dvsr[0] = 4;
        check("dvsr_same_edge", m_dvsr, 4);
        frame(8'h96);
        // Reset in the middle of DATA with a divisor pending.
        accept(8'h5A, 1'b0);
        for (int k = 0; k < 400 && m_tx; k++) @(negedge clk);
        repeat (12) @(negedge clk);
        cfg_wr = 1'b1;
        cfg_dvsr = 11'd9;
        @(negedge clk);
        cfg_wr = 1'b0;
        check("busy_before_rst", m_busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_tx", m_tx, 1);
        check("midrst_busy", m_busy, 0);
        check("midrst_dvsr", m_dvsr, 325);
        check("midrst_ready", m_ready, 1);
        exp_dvsr = '{325, 325};
        cfg_write(11'd4, 4, 1'b0);
        accept(8'hE7, 1'b0);
        frame(8'hE7);
        // Parity / two stop bits instance.
        sel = 1'b1;
        @(negedge clk);
        cfg_write(11'd3, 3, 1'b0);
        accept(8'h07, 1'b0);
        frame(8'h07);
        // Randomized traffic on both instances.
        for (int r = 0; r < 26; r++) begin
            int mode = $urandom_range(0, 3);
            logic [10:0] v = 11'($urandom_range(0, 6));
            logic [7:0] d = 8'($urandom);
            sel = r >= 18;
            @(negedge clk);
            if (mode == 1) cfg_write(v, v != 0 ? int'(v) : exp_dvsr[sel], v == 0);
            if (mode == 3) begin
                w_at[0] = $urandom_range(0, 9);
                w_v[0] = v;
                w_at[1] = w_at[0] + 1 + $urandom_range(0, 5);
                w_v[1] = 11'($urandom_range(0, 6));
            end
            if (mode == 2) begin
                v = 11'($urandom_range(1, 6));
                cfg_wr = 1'b1;
                cfg_dvsr = v;
                tx_data = d;
                tx_valid = 1'b1;
                @(negedge clk);
                cfg_wr = 1'b0;
                tx_valid = 1'b0;
                exp_dvsr[sel] = int'(v);
                check("rand_dvsr_same_edge", m_dvsr, v);
            end else begin
                accept(d, 1'b0);
            end
            frame(d);
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
